ring_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream resource (e.g. a shift/ring datapath) among N requesters. Priority is held in a one-hot ring pointer that rotates like a ring counter: after each grant it moves to the position just past the winner. Grants are registered, one-hot and exclusive. The owner keeps the grant until it drops its request, or until its quantum expires when the optional preemption feature is built in.

---
 rtl/ring_arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 37 +++
 rtl/ring_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_ring_rr_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_arb_pkg.sv
// Shared types and defaults for the ring round-robin arbiter.
//   state_t       : arbiter FSM states (IDLE, BUSY)
//   DEF_N         : default requester count
//   DEF_QUANTUM   : default preemption quantum (RR_TIMEOUT_EN builds)
//   CNT_W         : quantum counter width
//   id_width(n)   : binary index width for n requesters
package ring_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int unsigned DEF_N       = 4;
  localparam int unsigned DEF_QUANTUM = 8;
  localparam int unsigned CNT_W       = 8;

  // Index width; never below one bit so a degenerate N still elaborates.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder.
//   req_i    : candidate request vector
//   ptr_i    : one-hot priority pointer (highest-priority position)
//   win_o    : one-hot winner (zero when req_i is zero)
//   win_id_o : binary index of the winner
//   any_o    : any candidate present
module rr_pick
  import ring_arb_pkg::*;
#(
  parameter  int unsigned N   = DEF_N,
  localparam int unsigned IDW = id_width(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [N-1:0]   ptr_i,
  output logic [N-1:0]   win_o,
  output logic [IDW-1:0] win_id_o,
  output logic           any_o
);

  logic [N-1:0] upper;
  logic [N-1:0] masked;
  logic [N-1:0] pool;

  // Search from ptr upward; if nothing there, wrap and take the lowest set bit.
  always_comb begin
    upper    = ~(ptr_i - N'(1));
    masked   = req_i & upper;
    pool     = (|masked) ? masked : req_i;
    win_o    = pool & (~pool + N'(1));
    win_id_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (win_o[i]) win_id_o = IDW'(i);
    end
    any_o    = |req_i;
  end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot ring priority pointer.
// Optional quantum preemption is built in when RR_TIMEOUT_EN is defined.
//   Clk         : clock
//   rst         : asynchronous active-high reset
//   req         : request vector
//   grant       : registered one-hot grant (zero when idle)
//   grant_valid : any grant bit set
//   grant_id    : binary index of the granted requester
//   ptr         : registered one-hot priority pointer
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter  int unsigned N       = DEF_N,
  parameter  int unsigned QUANTUM = DEF_QUANTUM,
  localparam int unsigned IDW     = id_width(N)
) (
  input  logic           Clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id,
  output logic [N-1:0]   ptr
);

  // Elaboration-time parameter range checks.
  if (N < 2 || N > 16) begin : g_bad_n
    $error("ring_rr_arbiter: N out of range 2..16");
  end
  if (QUANTUM < 2 || QUANTUM > 255) begin : g_bad_q
    $error("ring_rr_arbiter: QUANTUM out of range 2..255");
  end

  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           valid_q, valid_d;
  logic [IDW-1:0] id_q, id_d;
  logic [N-1:0]   ptr_q, ptr_d;
`ifdef RR_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic [N-1:0]   cand;
  logic [N-1:0]   win;
  logic [IDW-1:0] win_id;
  logic           win_any;
  logic           owner_req;
  logic           load;

  // While busy the owner is excluded, so any winner is a genuine other requester.
  always_comb begin
    cand      = (state_q == BUSY) ? (req & ~grant_q) : req;
    owner_req = |(req & grant_q);
  end

  rr_pick #(.N(N)) u_pick (
    .req_i    (cand),
    .ptr_i    (ptr_q),
    .win_o    (win),
    .win_id_o (win_id),
    .any_o    (win_any)
  );

  // Next-state and grant/pointer update.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    load    = 1'b0;
`ifdef RR_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_any) load = 1'b1;
      end
      BUSY: begin
        if (!owner_req) begin
          if (win_any) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = '0;
`ifdef RR_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
`ifdef RR_TIMEOUT_EN
        // Quantum spent: hand off if someone waits, otherwise saturate.
        else if (cnt_q == CNT_W'(QUANTUM - 1)) begin
          if (win_any) load = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = BUSY;
      grant_d = win;
      id_d    = win_id;
      ptr_d   = {win[N-2:0], win[N-1]};
`ifdef RR_TIMEOUT_EN
      cnt_d   = '0;
`endif
    end
    valid_d = |grant_d;
  end

  // State registers.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= N'(1);
`ifdef RR_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
`ifdef RR_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;
  assign ptr         = ptr_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Self-checking bench for ring_rr_arbiter (N=4, QUANTUM=4) against a
// behavioural owner/priority model.
module tb_ring_rr_arbiter;

  localparam int N = 4;
  localparam int Q = 4;

  logic       Clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [3:0] ptr;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: current owner (-1 = none), highest-priority index, cycles owned.
  int m_owner = -1;
  int m_prio  = 0;
  int m_held  = 0;

  ring_rr_arbiter #(.N(N), .QUANTUM(Q)) dut (
    .Clk         (Clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .ptr         (ptr)
  );

  always #5 Clk = ~Clk;

  task automatic model_reset();
    m_owner = -1;
    m_prio  = 0;
    m_held  = 0;
  endtask

  // One clock edge of arbitration as described by the rules.
  task automatic model_step(input logic [3:0] r);
    int  w;
    bit  keep;
    bit  others;
    w      = -1;
    keep   = 1'b0;
    others = 1'b0;
    for (int i = 0; i < N; i++) if (r[i] && i != m_owner) others = 1'b1;
    if (m_owner >= 0) begin
      if (r[m_owner]) begin
        keep = 1'b1;
`ifdef RR_TIMEOUT_EN
        if (m_held == Q - 1 && others) keep = 1'b0;
`endif
      end
    end
    if (keep) begin
      if (m_held < Q - 1) m_held++;
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_prio + k) % N;
        if (w < 0 && r[i] && i != m_owner) w = i;
      end
      if (w >= 0) begin
        m_owner = w;
        m_prio  = (w + 1) % N;
        m_held  = 0;
      end else begin
        m_owner = -1;
      end
    end
  endtask

  // Expected {grant, grant_valid, grant_id, ptr}.
  function automatic logic [10:0] exp_vec();
    logic [3:0] g;
    logic [1:0] id;
    g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    return {g, (m_owner >= 0), id, 4'(1 << m_prio)};
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    rst = 1'b1;
    req = 4'b0;
    @(negedge Clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    repeat (2) @(negedge Clk);
    model_reset();
    n_tests++;
    if ({grant, grant_valid, grant_id, ptr} !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset: got %b want %b", {grant, grant_valid, grant_id, ptr}, exp_vec());
    end
    rst = 1'b0;
    req = 4'b0;
  endtask

  task automatic test_single();
    logic [3:0] seq [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                            4'b0000, 4'b0000};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req = seq[c];
      @(posedge Clk);
      model_step(req);
      @(negedge Clk);
      n_tests++;
      if ({grant, grant_valid, grant_id, ptr} !== exp_vec()) begin
        n_fail++;
        $display("FAIL single[%0d]: got %b want %b", c, {grant, grant_valid, grant_id, ptr}, exp_vec());
      end
    end
  endtask

  task automatic test_rotation();
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      @(posedge Clk);
      model_step(req);
      @(negedge Clk);
      n_tests++;
      if ({grant, grant_valid, grant_id, ptr} !== exp_vec()) begin
        n_fail++;
        $display("FAIL rotation[%0d]: got %b want %b", c, {grant, grant_valid, grant_id, ptr}, exp_vec());
      end
      // Owner drops its request for one cycle after two cycles of ownership.
      if (m_owner >= 0 && m_held >= 1) req = 4'b1111 & ~4'(1 << m_owner);
      else req = 4'b1111;
    end
  endtask

  task automatic test_wrap();
    logic [3:0] seq [5] = '{4'b0010, 4'b0000, 4'b0011, 4'b0011, 4'b0010};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      req = seq[c];
      @(posedge Clk);
      model_step(req);
      @(negedge Clk);
      n_tests++;
      if ({grant, grant_valid, grant_id, ptr} !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got %b want %b", c, {grant, grant_valid, grant_id, ptr}, exp_vec());
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] seq [6] = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b1010, 4'b0010};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      req = seq[c];
      @(posedge Clk);
      model_step(req);
      @(negedge Clk);
      n_tests++;
      if ({grant, grant_valid, grant_id, ptr} !== exp_vec()) begin
        n_fail++;
        $display("FAIL simultaneous[%0d]: got %b want %b", c, {grant, grant_valid, grant_id, ptr}, exp_vec());
      end
    end
  endtask

  task automatic test_preempt();
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 20; c++) begin
      @(posedge Clk);
      model_step(req);
      @(negedge Clk);
      n_tests++;
      if ({grant, grant_valid, grant_id, ptr} !== exp_vec()) begin
        n_fail++;
        $display("FAIL preempt_pair[%0d]: got %b want %b", c, {grant, grant_valid, grant_id, ptr}, exp_vec());
      end
    end
    req = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      @(posedge Clk);
      model_step(req);
      @(negedge Clk);
      n_tests++;
      if ({grant, grant_valid, grant_id, ptr} !== exp_vec()) begin
        n_fail++;
        $display("FAIL preempt_alone[%0d]: got %b want %b", c, {grant, grant_valid, grant_id, ptr}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      // Bias owners to keep requesting so grants span several cycles.
      if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
      req = r;
      @(posedge Clk);
      model_step(req);
      @(negedge Clk);
      n_tests++;
      if ({grant, grant_valid, grant_id, ptr} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: req %b got %b want %b", c, req, {grant, grant_valid, grant_id, ptr}, exp_vec());
      end
    end
  endtask

  task automatic test_reset_midgrant();
    do_reset();
    req = 4'b0110;
    repeat (3) begin
      @(posedge Clk);
      model_step(req);
    end
    @(negedge Clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if ({grant, grant_valid, grant_id, ptr} !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_async: got %b want %b", {grant, grant_valid, grant_id, ptr}, exp_vec());
    end
    @(negedge Clk);
    rst = 1'b0;
    req = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      @(posedge Clk);
      model_step(req);
      @(negedge Clk);
      n_tests++;
      if ({grant, grant_valid, grant_id, ptr} !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_after[%0d]: got %b want %b", c, {grant, grant_valid, grant_id, ptr}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_simultaneous();
    test_preempt();
    test_random();
    test_reset_midgrant();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
